lift_scan_ctrl: RTL and testbench

- Parametrised multi-request elevator car controller. It latches floor requests into a pending bitmap and services them in SCAN order: it keeps travelling in the current direction while requests remain ahead, then reverses.
- Models per-floor travel time and a door dwell timer.
- Sits between the floor/cabin request decoders and the motor/door drivers. It generalises the single-target lift controller to N floors and queued requests.

---
 rtl/lift_scan_ctrl_if.sv | 27 ++
 rtl/lift_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lift_scan_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lift_scan_ctrl_if.sv
// Request and status bundle between the request decoders, the lift controller and the drivers.
interface lift_scan_ctrl_if #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = 3
);
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  up;
    logic                  down;
    logic                  stop;
    logic                  door;
    logic [NUM_FLOORS-1:0] pending;
    logic                  busy;

    // Request side: issues floor requests, observes car status
    modport master (
        output req_valid, req_floor,
        input  cur_floor, up, down, stop, door, pending, busy
    );

    // Controller side
    modport slave (
        input  req_valid, req_floor,
        output cur_floor, up, down, stop, door, pending, busy
    );
endinterface

// File: rtl/lift_scan_ctrl.sv
// SCAN-order multi-request elevator controller with per-floor travel time and door dwell.
module lift_scan_ctrl #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = 3,
    parameter int unsigned TRAVEL_CYC = 4,
    parameter int unsigned DOOR_CYC   = 6
) (
    input  logic            clk,
    input  logic            reset,
    lift_scan_ctrl_if.slave bus
);
    localparam int unsigned CNT_MAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    state_t                r_state;
    dir_t                  r_dir;
    logic [CNT_W-1:0]      r_cnt;
    logic [FLOOR_W-1:0]    r_cur_floor;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_up;
    logic                  r_down;
    logic                  r_stop;
    logic                  r_door;
    logic                  r_busy;

    state_t                w_state_nxt;
    dir_t                  w_dir_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [FLOOR_W-1:0]    w_floor_nxt;
    logic [NUM_FLOORS-1:0] w_pend_nxt;

    logic                  w_req_ok;
    logic [NUM_FLOORS-1:0] w_req_vec;
    logic [NUM_FLOORS-1:0] w_pend_in;
    logic [NUM_FLOORS-1:0] w_bit_cur;
    logic [FLOOR_W-1:0]    w_floor_step;
    logic [NUM_FLOORS-1:0] w_bit_step;
    logic                  w_ahead_up;
    logic                  w_ahead_dn;
    logic                  w_step_ahead;

    // Any requested floor strictly above flr
    function automatic logic any_above(input logic [NUM_FLOORS-1:0] vec,
                                       input logic [FLOOR_W-1:0]    flr);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (vec[i] && (i > 32'(flr))) hit = 1'b1;
        end
        return hit;
    endfunction

    // Any requested floor strictly below flr
    function automatic logic any_below(input logic [NUM_FLOORS-1:0] vec,
                                       input logic [FLOOR_W-1:0]    flr);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (vec[i] && (i < 32'(flr))) hit = 1'b1;
        end
        return hit;
    endfunction

    // Request decode; out-of-range floors never reach the bitmap
    assign w_req_ok     = bus.req_valid && (32'(bus.req_floor) < NUM_FLOORS);
    assign w_req_vec    = w_req_ok ? (NUM_FLOORS'(1) << bus.req_floor) : '0;
    assign w_pend_in    = r_pending | w_req_vec;
    assign w_bit_cur    = NUM_FLOORS'(1) << r_cur_floor;
    assign w_floor_step = (r_dir == DIR_UP) ? (r_cur_floor + FLOOR_W'(1))
                                            : (r_cur_floor - FLOOR_W'(1));
    assign w_bit_step   = NUM_FLOORS'(1) << w_floor_step;
    assign w_ahead_up   = any_above(r_pending, r_cur_floor);
    assign w_ahead_dn   = any_below(r_pending, r_cur_floor);
    // Arrival look-ahead includes a request landing on the same edge
    assign w_step_ahead = (r_dir == DIR_UP) ? any_above(w_pend_in, w_floor_step)
                                            : any_below(w_pend_in, w_floor_step);

    // Next-state logic: SCAN decision in IDLE, travel timing in MOVE, dwell in DOOR
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_floor_nxt = r_cur_floor;
        w_pend_nxt  = w_pend_in;
        case (r_state)
            S_IDLE: begin
                if (|(r_pending & w_bit_cur)) begin
                    w_state_nxt = S_DOOR;
                    w_cnt_nxt   = CNT_W'(DOOR_CYC - 1);
                    w_pend_nxt  = w_pend_in & ~w_bit_cur;
                end else if ((r_dir == DIR_UP) && w_ahead_up) begin
                    w_state_nxt = S_MOVE;
                    w_cnt_nxt   = CNT_W'(TRAVEL_CYC - 1);
                end else if ((r_dir == DIR_UP) && w_ahead_dn) begin
                    w_state_nxt = S_MOVE;
                    w_dir_nxt   = DIR_DN;
                    w_cnt_nxt   = CNT_W'(TRAVEL_CYC - 1);
                end else if ((r_dir == DIR_DN) && w_ahead_dn) begin
                    w_state_nxt = S_MOVE;
                    w_cnt_nxt   = CNT_W'(TRAVEL_CYC - 1);
                end else if ((r_dir == DIR_DN) && w_ahead_up) begin
                    w_state_nxt = S_MOVE;
                    w_dir_nxt   = DIR_UP;
                    w_cnt_nxt   = CNT_W'(TRAVEL_CYC - 1);
                end
            end
            S_MOVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_floor_nxt = w_floor_step;
                    if (|(w_pend_in & w_bit_step)) begin
                        w_state_nxt = S_DOOR;
                        w_cnt_nxt   = CNT_W'(DOOR_CYC - 1);
                        w_pend_nxt  = w_pend_in & ~w_bit_step;
                    end else if (w_step_ahead) begin
                        w_cnt_nxt = CNT_W'(TRAVEL_CYC - 1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                if (w_req_ok && (bus.req_floor == r_cur_floor)) begin
                    // Hall call at the open floor extends the dwell instead of queueing
                    w_cnt_nxt  = CNT_W'(DOOR_CYC - 1);
                    w_pend_nxt = r_pending;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dir       <= DIR_UP;
            r_cnt       <= '0;
            r_cur_floor <= '0;
            r_pending   <= '0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
            r_stop      <= 1'b1;
            r_door      <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dir       <= w_dir_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cur_floor <= w_floor_nxt;
            r_pending   <= w_pend_nxt;
            r_up        <= (w_state_nxt == S_MOVE) && (w_dir_nxt == DIR_UP);
            r_down      <= (w_state_nxt == S_MOVE) && (w_dir_nxt == DIR_DN);
            r_stop      <= (w_state_nxt != S_MOVE);
            r_door      <= (w_state_nxt != S_MOVE);
            r_busy      <= (w_pend_nxt != '0) || (w_state_nxt != S_IDLE);
        end
    end

    assign bus.cur_floor = r_cur_floor;
    assign bus.up        = r_up;
    assign bus.down      = r_down;
    assign bus.stop      = r_stop;
    assign bus.door      = r_door;
    assign bus.pending   = r_pending;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Testbench for lift_scan_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_lift_scan_ctrl;
    localparam int unsigned NF = 6;
    localparam int unsigned FW = 3;
    localparam int unsigned TC = 4;
    localparam int unsigned DC = 6;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic clk = 1'b0;
    logic reset;

    lift_scan_ctrl_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    lift_scan_ctrl #(
        .NUM_FLOORS(NF),
        .FLOOR_W   (FW),
        .TRAVEL_CYC(TC),
        .DOOR_CYC  (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: car position, activity and remaining time in that activity
    int          m_floor;
    int          m_mode;
    int          m_tleft;
    int          m_dleft;
    bit          m_dir_up;
    bit [NF-1:0] m_pend;

    logic prev_stop = 1'b1;
    int   stops[$];

    function automatic bit beyond(input bit [NF-1:0] p, input int f, input bit upward);
        for (int i = 0; i < int'(NF); i++) begin
            if (p[i] && (upward ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_step(input bit rst, input bit v, input int f);
        bit [NF-1:0] rq;
        bit [NF-1:0] one;
        one = 1;
        if (rst) begin
            m_floor = 0; m_mode = M_IDLE; m_tleft = 0; m_dleft = 0;
            m_dir_up = 1'b1; m_pend = '0;
            return;
        end
        rq = (v && (f < int'(NF))) ? (one << f) : '0;
        if (m_mode == M_IDLE) begin
            if (m_pend[m_floor]) begin
                m_mode  = M_DOOR;
                m_dleft = DC;
                m_pend  = (m_pend | rq) & ~(one << m_floor);
            end else begin
                if (m_dir_up && !beyond(m_pend, m_floor, 1'b1) && beyond(m_pend, m_floor, 1'b0))
                    m_dir_up = 1'b0;
                else if (!m_dir_up && !beyond(m_pend, m_floor, 1'b0) && beyond(m_pend, m_floor, 1'b1))
                    m_dir_up = 1'b1;
                if (beyond(m_pend, m_floor, m_dir_up)) begin
                    m_mode  = M_MOVE;
                    m_tleft = TC;
                end
                m_pend = m_pend | rq;
            end
        end else if (m_mode == M_MOVE) begin
            m_pend = m_pend | rq;
            if (m_tleft > 1) begin
                m_tleft--;
            end else begin
                m_floor = m_dir_up ? m_floor + 1 : m_floor - 1;
                if (m_pend[m_floor]) begin
                    m_mode  = M_DOOR;
                    m_dleft = DC;
                    m_pend  = m_pend & ~(one << m_floor);
                end else if (beyond(m_pend, m_floor, m_dir_up)) begin
                    m_tleft = TC;
                end else begin
                    m_mode = M_IDLE;
                end
            end
        end else begin
            if (v && (f == m_floor)) begin
                m_dleft = DC;
            end else begin
                m_pend = m_pend | rq;
                if (m_dleft == 1) m_mode = M_IDLE;
                else m_dleft--;
            end
        end
    endtask

    task automatic compare_all();
        chk("cur_floor", 32'(bus.cur_floor), 32'(m_floor));
        chk("up",        32'(bus.up),        32'(m_mode == M_MOVE && m_dir_up));
        chk("down",      32'(bus.down),      32'(m_mode == M_MOVE && !m_dir_up));
        chk("stop",      32'(bus.stop),      32'(m_mode != M_MOVE));
        chk("door",      32'(bus.door),      32'(m_mode != M_MOVE));
        chk("pending",   32'(bus.pending),   32'(m_pend));
        chk("busy",      32'(bus.busy),      32'((m_pend != '0) || (m_mode != M_IDLE)));
        chk("up_dn_excl", 32'(bus.up & bus.down), 32'(0));
    endtask

    task automatic tick(input bit rst, input bit v, input int f);
        reset         = rst;
        bus.req_valid = v;
        bus.req_floor = FW'(f);
        @(posedge clk);
        model_step(rst, v, f);
        #1;
        compare_all();
        if (prev_stop === 1'b0 && bus.stop === 1'b1) stops.push_back(int'(bus.cur_floor));
        prev_stop = bus.stop;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int k = 0; k < max_cyc && bus.busy === 1'b1; k++) tick(1'b0, 1'b0, 0);
        chk("idle_reached", 32'(bus.busy), 32'(0));
    endtask

    initial begin
        int n_up;
        int n_door;
        int exp_order[3];
        exp_order = '{4, 5, 0};
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_floor = '0;

        // Reset then idle
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 0);
        chk("rst_floor", 32'(bus.cur_floor), 32'(0));
        chk("rst_stop",  32'(bus.stop), 32'(1));
        chk("rst_door",  32'(bus.door), 32'(1));
        chk("rst_busy",  32'(bus.busy), 32'(0));

        // Single trip 0 -> 3
        tick(1'b0, 1'b1, 3);
        n_up = 0;
        for (int k = 0; k < 100 && bus.busy === 1'b1; k++) begin
            tick(1'b0, 1'b0, 0);
            if (bus.up === 1'b1) n_up++;
        end
        chk("trip_up_cycles", 32'(n_up), 32'(3 * TC));
        chk("trip_floor", 32'(bus.cur_floor), 32'(3));

        // SCAN order from floor 2 heading up
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, 2);
        wait_idle(100);
        stops.delete();
        tick(1'b0, 1'b1, 5);
        tick(1'b0, 1'b1, 0);
        tick(1'b0, 1'b1, 4);
        wait_idle(200);
        chk("scan_nstops", 32'(stops.size()), 32'(3));
        if (stops.size() == 3)
            for (int i = 0; i < 3; i++) chk("scan_order", 32'(stops[i]), 32'(exp_order[i]));

        // Door extension at floor 3
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, 3);
        for (int k = 0; k < 100 && bus.cur_floor !== FW'(3); k++) tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b1, 3);
        chk("ext_pending", 32'(bus.pending), 32'(0));
        n_door = (bus.busy === 1'b1) ? 1 : 0;
        for (int k = 0; k < 50 && bus.busy === 1'b1; k++) begin
            tick(1'b0, 1'b0, 0);
            if (bus.busy === 1'b1) n_door++;
        end
        chk("ext_dwell", 32'(n_door), 32'(DC));

        // Out-of-range requests, then top floor
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, 7);
        tick(1'b0, 1'b1, 6);
        chk("oor_pending", 32'(bus.pending), 32'(0));
        chk("oor_busy",    32'(bus.busy), 32'(0));
        tick(1'b0, 1'b1, 5);
        wait_idle(200);
        chk("top_floor", 32'(bus.cur_floor), 32'(NF - 1));

        // Reset mid-travel between 2 and 3
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, 4);
        for (int k = 0; k < 100 && bus.cur_floor !== FW'(2); k++) tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        chk("mid_moving", 32'(bus.up), 32'(1));
        tick(1'b1, 1'b0, 0);
        chk("mid_floor",   32'(bus.cur_floor), 32'(0));
        chk("mid_pending", 32'(bus.pending), 32'(0));
        chk("mid_stop",    32'(bus.stop), 32'(1));
        chk("mid_door",    32'(bus.door), 32'(1));
        chk("mid_up",      32'(bus.up), 32'(0));

        // Random traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            tick(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 99) < 20),
                 int'($urandom_range(0, 7)));
        end
        wait_idle(400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
